// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle: latched instruction fields in, register-bank write port and decode bypass out.
interface writeback_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [1:0]        flagsWB;
  logic [4:0]        rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [47:0]       pc1;

  logic              reg_wr;
  logic [4:0]        dir_wra;
  logic [DATA_W-1:0] data_out;
  logic              fwd_valid;
  logic [4:0]        fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, flagsWB, rd, alu_result, mem_data, pc1,
    input  reg_wr, dir_wra, data_out, fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  in_valid, flagsWB, rd, alu_result, mem_data, pc1,
    output reg_wr, dir_wra, data_out, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: one-deep latch with a single-commit FSM, retire counter and last-PC tracker.
// Defining WB_BYPASS_EN drives the decode bypass from the write port; otherwise it is tied off.
module writeback_stage #(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  writeback_stage_if.slave wb,
  output logic [31:0]      retired_count,
  output logic [47:0]      last_pc
);
  localparam int PC_W = 48;

  typedef enum logic [1:0] {EMPTY, NEW, HELD} state_t;

  state_t            state_p1;
  logic [1:0]        flags_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] aluResult_p1;
  logic [DATA_W-1:0] memData_p1;
  logic [PC_W-1:0]   pc_p1;

  logic [31:0]       retiredCnt;
  logic [PC_W-1:0]   lastPc;
  logic              commit;

  // ---- stage p1: latch and commit FSM ----
  // HELD marks an instruction that already committed, so a long stall never commits it again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= EMPTY;
      flags_p1     <= '0;
      rd_p1        <= '0;
      aluResult_p1 <= '0;
      memData_p1   <= '0;
      pc_p1        <= '0;
    end else if (flush) begin
      state_p1 <= EMPTY;
    end else if (stall) begin
      state_p1 <= (state_p1 == EMPTY) ? EMPTY : HELD;
    end else begin
      state_p1     <= wb.in_valid ? NEW : EMPTY;
      flags_p1     <= wb.flagsWB;
      rd_p1        <= wb.rd;
      aluResult_p1 <= wb.alu_result;
      memData_p1   <= wb.mem_data;
      pc_p1        <= wb.pc1;
    end
  end

  assign commit = (state_p1 == NEW);

  // ---- retire bookkeeping, updated at the end of each commit cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      retiredCnt <= '0;
      lastPc     <= '0;
    end else begin
      retiredCnt <= retiredCnt + {31'd0, commit};
      if (commit) lastPc <= pc_p1;
    end
  end

  assign retired_count = retiredCnt;
  assign last_pc       = lastPc;

  assign wb.reg_wr   = commit & flags_p1[0];
  assign wb.dir_wra  = rd_p1;
  assign wb.data_out = flags_p1[1] ? memData_p1 : aluResult_p1;

`ifdef WB_BYPASS_EN
  assign wb.fwd_valid = wb.reg_wr;
  assign wb.fwd_addr  = wb.dir_wra;
  assign wb.fwd_data  = wb.data_out;
`else
  assign wb.fwd_valid = 1'b0;
  assign wb.fwd_addr  = '0;
  assign wb.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a queue of expected register writes is checked by a
// negedge monitor, while the main thread checks counters, last PC and bypass values.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] retired_count;
  logic [47:0] last_pc;

  writeback_stage_if #(.DATA_W(32)) wb ();

  writeback_stage #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .wb            (wb),
    .retired_count (retired_count),
    .last_pc       (last_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   total    = 0;
  int   bad      = 0;
  int   monTotal = 0;
  int   monBad   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [1:0] f, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [47:0] pc);
    exp_t e;
    wb.in_valid   = v;
    wb.flagsWB    = f;
    wb.rd         = r;
    wb.alu_result = alu;
    wb.mem_data   = mem;
    wb.pc1        = pc;
    stall = 1'b0;
    flush = 1'b0;
    if (v && f[0]) begin
      e.addr = r;
      e.data = f[1] ? mem : alu;
      expQ.push_back(e);
    end
    cyc();
    wb.in_valid = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (wb.reg_wr === 1'b1) begin
      monTotal++;
      if (expQ.size() == 0) begin
        monBad++;
        $display("FAIL wr_unexpected: got addr=%0d data=0x%0h, expected no write", wb.dir_wra, wb.data_out);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (wb.dir_wra !== e.addr || wb.data_out !== e.data) begin
          monBad++;
          $display("FAIL wr_data: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                   wb.dir_wra, wb.data_out, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wb.in_valid = 1'b0; wb.flagsWB = 2'b00; wb.rd = '0;
    wb.alu_result = '0; wb.mem_data = '0; wb.pc1 = '0;
    cyc(); cyc();
    rst = 1'b0;

    check("rst_reg_wr",   {63'd0, wb.reg_wr}, 64'd0);
    check("rst_dir_wra",  {59'd0, wb.dir_wra}, 64'd0);
    check("rst_data_out", {32'd0, wb.data_out}, 64'd0);
    check("rst_fwd",      {26'd0, wb.fwd_valid, wb.fwd_addr, wb.fwd_data}, 64'd0);
    check("rst_retired",  {32'd0, retired_count}, 64'd0);
    check("rst_last_pc",  {16'd0, last_pc}, 64'd0);

    // Basic ALU write
    issue(1'b1, 2'b01, 5'd5, 32'h0000_00AA, 32'h0, 48'h1000);
    check("alu_reg_wr",   {63'd0, wb.reg_wr}, 64'd1);
    check("alu_dir_wra",  {59'd0, wb.dir_wra}, 64'd5);
    check("alu_data_out", {32'd0, wb.data_out}, 64'hAA);
    cyc();
    check("alu_retired",  {32'd0, retired_count}, 64'd1);
    check("alu_last_pc",  {16'd0, last_pc}, 64'h1000);
    check("alu_idle",     {63'd0, wb.reg_wr}, 64'd0);

    // Memory select
    issue(1'b1, 2'b11, 5'd9, 32'h1, 32'hDEAD_BEEF, 48'h2000);
    check("mem_data_out", {32'd0, wb.data_out}, 64'hDEAD_BEEF);
    cyc();
    check("mem_retired",  {32'd0, retired_count}, 64'd2);

    // Commit without register write still retires; rd=0 is an ordinary write
    issue(1'b1, 2'b00, 5'd4, 32'h44, 32'h0, 48'h3000);
    check("nowr_reg_wr",  {63'd0, wb.reg_wr}, 64'd0);
    cyc();
    check("nowr_retired", {32'd0, retired_count}, 64'd3);
    check("nowr_last_pc", {16'd0, last_pc}, 64'h3000);
    issue(1'b1, 2'b01, 5'd0, 32'h55, 32'h0, 48'h3100);
    check("rd0_reg_wr",   {63'd0, wb.reg_wr}, 64'd1);
    check("rd0_dir_wra",  {59'd0, wb.dir_wra}, 64'd0);
    cyc();
    check("rd0_retired",  {32'd0, retired_count}, 64'd4);

    // Stall hold: one commit only, new input offered during stall is not taken
    issue(1'b1, 2'b01, 5'd7, 32'h77, 32'h0, 48'h4000);
    stall = 1'b1;
    wb.in_valid = 1'b1; wb.rd = 5'd8; wb.alu_result = 32'h88; wb.pc1 = 48'h4100;
    for (int i = 0; i < 4; i++) cyc();
    check("stall_retired", {32'd0, retired_count}, 64'd5);
    check("stall_dir_wra", {59'd0, wb.dir_wra}, 64'd7);
    check("stall_reg_wr",  {63'd0, wb.reg_wr}, 64'd0);
    check("stall_last_pc", {16'd0, last_pc}, 64'h4000);
    stall = 1'b0; wb.in_valid = 1'b0;
    cyc();
    check("stall_after",   {32'd0, retired_count}, 64'd5);

    // Flush with stall on the same edge: commit in progress survives, nothing after
    issue(1'b1, 2'b01, 5'd10, 32'hA0, 32'h0, 48'h5000);
    flush = 1'b1; stall = 1'b1;
    cyc();
    check("flush_reg_wr",  {63'd0, wb.reg_wr}, 64'd0);
    check("flush_retired", {32'd0, retired_count}, 64'd6);
    flush = 1'b0;
    cyc();
    check("flush_hold",    {32'd0, retired_count}, 64'd6);
    // Flush outranks a valid capture
    stall = 1'b0; flush = 1'b1;
    wb.in_valid = 1'b1; wb.flagsWB = 2'b01; wb.rd = 5'd11;
    cyc();
    flush = 1'b0; wb.in_valid = 1'b0;
    check("flush_cap_wr",  {63'd0, wb.reg_wr}, 64'd0);
    cyc();
    check("flush_cap_cnt", {32'd0, retired_count}, 64'd6);

    // Bypass
    issue(1'b1, 2'b01, 5'd3, 32'h1234, 32'h0, 48'h7000);
    check("byp_valid", {63'd0, wb.fwd_valid}, BYP ? 64'd1 : 64'd0);
    check("byp_addr",  {59'd0, wb.fwd_addr},  BYP ? 64'd3 : 64'd0);
    check("byp_data",  {32'd0, wb.fwd_data},  BYP ? 64'h1234 : 64'd0);
    cyc();

    // Wrap-around of the retire counter
    force dut.retiredCnt = 32'hFFFF_FFFF;
    cyc();
    release dut.retiredCnt;
    check("wrap_pre", {32'd0, retired_count}, 64'hFFFF_FFFF);
    issue(1'b1, 2'b00, 5'd1, 32'h0, 32'h0, 48'h6000);
    cyc();
    check("wrap_post", {32'd0, retired_count}, 64'd0);
    check("wrap_pc",   {16'd0, last_pc}, 64'h6000);

    // Reset during a commit cycle: write still visible, counters clear
    issue(1'b1, 2'b01, 5'd12, 32'hC0, 32'h0, 48'h8000);
    rst = 1'b1;
    check("rstnew_reg_wr", {63'd0, wb.reg_wr}, 64'd1);
    cyc();
    rst = 1'b0;
    check("rstnew_retired", {32'd0, retired_count}, 64'd0);
    check("rstnew_last_pc", {16'd0, last_pc}, 64'd0);
    check("rstnew_outs",    {26'd0, wb.reg_wr, wb.dir_wra, wb.data_out}, 64'd0);

    cyc(); cyc();
    check("queue_drained", 64'(expQ.size()), 64'd0);

    total += monTotal;
    bad   += monBad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
